edg_frame_sched: RTL and testbench

//  Frame-level scheduler for the two-pixel edge-detect datapath. Walks a source

---
 rtl/edg_frame_sched_if.sv | 12 +
 rtl/edg_frame_sched.sv | 183 ++++++++++++++++++
 tb/tb_edg_frame_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/edg_frame_sched_if.sv
// Shared single-port memory bus between the frame scheduler (master) and ZBT memory (slave).
interface edg_frame_sched_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [35:0]       mem_wdata;
  logic [35:0]       mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/edg_frame_sched.sv
// Frame scheduler for the two-pixel edge datapath: even slots read source pairs, odd slots write results.
// Optional macro EDG_SCHED_PASSTHRU_EN adds a passthru input that copies the source frame unprocessed.
module edg_frame_sched #(
  parameter int ADDR_W   = 19,
  parameter int H_PAIRS  = 512,
  parameter int V_LINES  = 768,
  parameter int MEM_LAT  = 2,
  parameter int PROC_LAT = 2,
  parameter logic [ADDR_W-1:0] SRC_BASE = 19'h00000,
  parameter logic [ADDR_W-1:0] DST_BASE = 19'h40000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef EDG_SCHED_PASSTHRU_EN
  input  logic                passthru,
`endif
  output logic                busy,
  output logic                done,
  edg_frame_sched_if.master   mem,
  output logic [35:0]         pix_pair,
  output logic [10:0]         pix_hcount,
  output logic                pix_valid,
  input  logic [35:0]         proc_pair,
  output logic                ovf_err
);

  localparam int XW = (H_PAIRS > 1) ? $clog2(H_PAIRS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic                slot;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [ADDR_W-1:0]   rd_cnt, wr_cnt, addr_q;
  logic [MEM_LAT-1:0]  vpipe;
  logic [10:0]         hpipe [MEM_LAT];
  logic [PROC_LAT-1:0] ppipe;
  logic [35:0]         fifo [4];
  logic [1:0]          wptr, rptr;
  logic [2:0]          fcount;
  logic                fifo_empty, fifo_full, push, push_ok;
  logic                read_fire, write_fire, last_read, pipes_empty;
  logic [35:0]         push_data;

  assign fifo_empty  = (fcount == 3'd0);
  assign fifo_full   = (fcount == 3'd4);
  assign last_read   = (x == XW'(H_PAIRS - 1)) && (y == YW'(V_LINES - 1));
  assign pipes_empty = (vpipe == '0) && (ppipe == '0) && fifo_empty;
  assign write_fire  = ((state == RUN) || (state == DRAIN)) && slot && !fifo_empty;
  assign push        = ppipe[PROC_LAT-1];
  assign push_ok     = push && (!fifo_full || write_fire);

  assign pix_pair      = mem.mem_rdata;
  assign pix_valid     = vpipe[MEM_LAT-1];
  assign pix_hcount    = hpipe[MEM_LAT-1];
  assign mem.mem_wdata = fifo[rptr];

  // Next state plus bus control; the address holds its last value when no slot is used.
  always_comb begin
    state_nxt    = state;
    read_fire    = 1'b0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    mem.mem_we   = 1'b0;
    mem.mem_addr = addr_q;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (!slot) begin
          read_fire    = 1'b1;
          mem.mem_addr = SRC_BASE + rd_cnt;
          if (last_read) state_nxt = DRAIN;
        end
      end
      DRAIN: if (pipes_empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (write_fire) begin
      mem.mem_we   = 1'b1;
      mem.mem_addr = DST_BASE + wr_cnt;
    end
  end

`ifdef EDG_SCHED_PASSTHRU_EN
  logic        passthru_q;
  logic [35:0] rdd [PROC_LAT];

  // Raw read data delayed to line up with the edge wrapper output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROC_LAT; i++) rdd[i] <= '0;
      passthru_q <= 1'b0;
    end else begin
      rdd[0] <= mem.mem_rdata;
      for (int i = 1; i < PROC_LAT; i++) rdd[i] <= rdd[i-1];
      if (state == IDLE && start) passthru_q <= passthru;
    end
  end

  assign push_data = passthru_q ? rdd[PROC_LAT-1] : proc_pair;
`else
  assign push_data = proc_pair;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      slot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= mem.mem_addr;
      if (state == IDLE && start) begin
        slot   <= 1'b0;
        x      <= '0;
        y      <= '0;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else if (state == RUN || state == DRAIN) begin
        slot <= ~slot;
      end
      if (read_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (x == XW'(H_PAIRS - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (write_fire) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Read tags ride alongside the memory latency, then the wrapper latency, before the FIFO push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
      ppipe <= '0;
      for (int i = 0; i < MEM_LAT; i++) hpipe[i] <= '0;
    end else begin
      vpipe[0] <= read_fire;
      hpipe[0] <= 11'({x, 1'b0});
      for (int i = 1; i < MEM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        hpipe[i] <= hpipe[i-1];
      end
      ppipe[0] <= vpipe[MEM_LAT-1];
      for (int i = 1; i < PROC_LAT; i++) ppipe[i] <= ppipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      fcount  <= '0;
      ovf_err <= 1'b0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo[wptr] <= push_data;
        wptr       <= wptr + 1'b1;
      end
      if (push && !push_ok) ovf_err <= 1'b1;
      if (write_fire) rptr <= rptr + 1'b1;
      case ({push_ok, write_fire})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

endmodule

// File: tb/tb_edg_frame_sched.sv
// Directed bench for edg_frame_sched on a 4x2-pair frame with a latency-2 memory and a +1 edge wrapper model.
module tb_edg_frame_sched;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NP = H * V;
  localparam logic [18:0] SRC = 19'h00000;
  localparam logic [18:0] DST = 19'h40000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pix_valid, ovf_err;
  logic [35:0] pix_pair, proc_pair;
  logic [10:0] pix_hcount;
`ifdef EDG_SCHED_PASSTHRU_EN
  logic        passthru;
`endif

  int total = 0;
  int bad   = 0;

  logic [35:0] srcmem [NP];
  logic [35:0] d1, d2, p1, p2;

  edg_frame_sched_if #(.ADDR_W(19)) mem_bus ();

  edg_frame_sched #(
    .ADDR_W(19), .H_PAIRS(H), .V_LINES(V), .MEM_LAT(2), .PROC_LAT(2),
    .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef EDG_SCHED_PASSTHRU_EN
    .passthru   (passthru),
`endif
    .busy       (busy),
    .done       (done),
    .mem        (mem_bus),
    .pix_pair   (pix_pair),
    .pix_hcount (pix_hcount),
    .pix_valid  (pix_valid),
    .proc_pair  (proc_pair),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] memRead(input logic [18:0] a);
    logic [2:0] idx;
    idx = a[2:0];
    if (a < 19'(NP)) return srcmem[idx];
    return 36'h0;
  endfunction

  // Two-stage memory read pipe and two-stage +1 edge wrapper.
  always @(posedge clk) begin
    d1 <= memRead(mem_bus.mem_addr);
    d2 <= d1;
    p1 <= pix_pair + 36'd1;
    p2 <= p1;
  end

  assign mem_bus.mem_rdata = d2;
  assign proc_pair         = p2;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One frame, checked cycle by cycle; k=0 is the first RUN cycle, reads on even k, first write at k=5.
  task automatic applyStimulus(input int hold, input int busyPoke, input int abortAt, input logic pt);
    logic        exp_we, exp_pv;
    int          ri, wi;
    start = 1'b1;
`ifdef EDG_SCHED_PASSTHRU_EN
    passthru = pt;
`endif
    @(posedge clk); #1;
    for (int k = 0; k < 24; k++) begin
      exp_we = (k % 2 == 1) && (k >= 5) && (k <= 19);
      exp_pv = (k % 2 == 0) && (k >= 2) && (k <= 16);
      checkOutput($sformatf("done k=%0d", k), 64'(done), 64'(k == 21));
      checkOutput($sformatf("busy k=%0d", k), 64'(busy), 64'(k <= 21));
      checkOutput($sformatf("ovf k=%0d", k), 64'(ovf_err), 64'(0));
      checkOutput($sformatf("we k=%0d", k), 64'(mem_bus.mem_we), 64'(exp_we));
      if (k % 2 == 0 && k <= 14)
        checkOutput($sformatf("rd_addr k=%0d", k), 64'(mem_bus.mem_addr), 64'(SRC + 19'(k / 2)));
      if (exp_we) begin
        wi = (k - 5) / 2;
        checkOutput($sformatf("wr_addr k=%0d", k), 64'(mem_bus.mem_addr), 64'(DST + 19'(wi)));
        checkOutput($sformatf("wr_data k=%0d", k), 64'(mem_bus.mem_wdata),
                    64'(pt ? srcmem[wi] : srcmem[wi] + 36'd1));
      end
      checkOutput($sformatf("pix_valid k=%0d", k), 64'(pix_valid), 64'(exp_pv));
      if (exp_pv) begin
        ri = (k - 2) / 2;
        checkOutput($sformatf("hcount k=%0d", k), 64'(pix_hcount), 64'(2 * (ri % H)));
        checkOutput($sformatf("pix_pair k=%0d", k), 64'(pix_pair), 64'(srcmem[ri]));
      end
      if (k == abortAt) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_we", 64'(mem_bus.mem_we), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_addr", 64'(mem_bus.mem_addr), 64'(0));
        checkOutput("abort_pv", 64'(pix_valid), 64'(0));
        start = 1'b0;
        return;
      end
      start = (k + 1 < hold) || (k == busyPoke);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
`ifdef EDG_SCHED_PASSTHRU_EN
    passthru = 1'b0;
`endif
    for (int i = 0; i < NP; i++) srcmem[i] = 36'hABC000000 + 36'(i) * 36'h10203;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_we", 64'(mem_bus.mem_we), 64'(0));
    checkOutput("rst_addr", 64'(mem_bus.mem_addr), 64'(0));
    checkOutput("rst_pv", 64'(pix_valid), 64'(0));
    checkOutput("rst_hcount", 64'(pix_hcount), 64'(0));
    checkOutput("rst_ovf", 64'(ovf_err), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic frame");
    applyStimulus(1, -1, -1, 1'b0);
    $display("[TB] back-to-back frame");
    applyStimulus(1, -1, -1, 1'b0);
    $display("[TB] long start and start while busy");
    applyStimulus(3, 8, -1, 1'b0);
    $display("[TB] reset after third write");
    applyStimulus(1, -1, 9, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1, -1, -1, 1'b0);
`ifdef EDG_SCHED_PASSTHRU_EN
    $display("[TB] passthru frames");
    applyStimulus(1, -1, -1, 1'b1);
    applyStimulus(1, -1, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
